// File: rtl/bit_sel_pkg.sv
// Shared definitions for the bit-window feeder and the 32x16 bit selector it drives.
package bit_sel_pkg;

    localparam int WINDOW_WIDTH  = 32;
    localparam int IN_WIDTH      = WINDOW_WIDTH / 2;
    localparam int COMMAND_WIDTH = $clog2(WINDOW_WIDTH);
    localparam int LEN_WIDTH     = 5;
    localparam int PTR_WIDTH     = 4;

    // Window occupancy in input words.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } win_state_t;

    localparam logic [COMMAND_WIDTH-1:0] CMD_NO_SHIFT = 5'b00000;

    // Pointer 0 means no shift; pointer p>0 selects shift p as {1, p-1}.
    // Shift 16 (5'b11111) is never produced because p stays within 0..15.
    function automatic logic [COMMAND_WIDTH-1:0] ptr_to_cmd(input logic [PTR_WIDTH-1:0] p);
        logic [COMMAND_WIDTH-1:0] cmd;
        if (p == '0) begin
            cmd = CMD_NO_SHIFT;
        end else begin
            cmd = {1'b1, p - 4'd1};
        end
        return cmd;
    endfunction

endpackage

// File: rtl/bit_sel_cmd_encode.sv
// Combinational bit pointer to selector command translation.
module bit_sel_cmd_encode
    import bit_sel_pkg::*;
(
    input  logic [PTR_WIDTH-1:0]     ptr,
    output logic [COMMAND_WIDTH-1:0] cmd
);

    // Pure lookup: the selector command follows the registered pointer.
    always_comb begin
        cmd = ptr_to_cmd(ptr);
    end

endmodule

// File: rtl/bit_window_feeder_32.sv
// Packs 16-bit words into a 32-bit sliding window and tracks the bit pointer
// for the downstream 32x16 selector.
// Optional build macro BIT_WINDOW_FLUSH_EN adds the i_flush input.
//
// Handshakes:
//   input word : transferred on a cycle where i_valid & i_ready are both high;
//                i_ready never depends on i_valid. i_ready also rises in a FULL
//                cycle whose advance drops the low word, so it has a
//                combinational path from i_adv_valid/i_adv_len.
//   advance    : i_adv_valid is a request that takes effect only while o_valid
//                is high; with o_valid low it is ignored (no backpressure).
// The window state is observable through the internal signal 'state'.
module bit_window_feeder_32
    import bit_sel_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_valid,
    output logic                     i_ready,
    input  logic [IN_WIDTH-1:0]      i_data,
    input  logic                     i_adv_valid,
    input  logic [LEN_WIDTH-1:0]     i_adv_len,
`ifdef BIT_WINDOW_FLUSH_EN
    input  logic                     i_flush,
`endif
    output logic                     o_valid,
    output logic                     o_en,
    output logic [WINDOW_WIDTH-1:0]  o_data_bus,
    output logic [COMMAND_WIDTH-1:0] o_cmd,
    output logic [PTR_WIDTH-1:0]     o_ptr
);

    win_state_t              state, state_nxt;
    logic [WINDOW_WIDTH-1:0] window, window_nxt;
    logic [PTR_WIDTH-1:0]    ptr, ptr_nxt;

    logic                    flush_req;
    logic [LEN_WIDTH-1:0]    len_sat;
    logic [5:0]              sum;
    logic                    adv_fire;
    logic                    drop;
    logic                    ready;
    logic                    accept;

`ifdef BIT_WINDOW_FLUSH_EN
    assign flush_req = i_flush;
`else
    assign flush_req = 1'b0;
`endif

    // State, window and pointer registers; rst discards everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= EMPTY;
            window <= '0;
            ptr    <= '0;
        end else begin
            state  <= state_nxt;
            window <= window_nxt;
            ptr    <= ptr_nxt;
        end
    end

    // Next-state, window shifting and pointer arithmetic.
    always_comb begin
        state_nxt  = state;
        window_nxt = window;
        ptr_nxt    = ptr;

        // Lengths above 16 are illegal and clamp to a full word.
        len_sat  = (i_adv_len > 5'd16) ? 5'd16 : i_adv_len;
        sum      = {2'b00, ptr} + {1'b0, len_sat};
        adv_fire = i_adv_valid & (state == FULL);
        drop     = adv_fire & (sum >= 6'd16);
        ready    = ~flush_req & ((state != FULL) | drop);
        accept   = i_valid & ready;

        unique case (state)
            EMPTY: begin
                if (accept) begin
                    window_nxt[IN_WIDTH-1:0] = i_data;
                    state_nxt                = HALF;
                end
            end
            HALF: begin
                if (accept) begin
                    window_nxt[WINDOW_WIDTH-1:IN_WIDTH] = i_data;
                    state_nxt                           = FULL;
                end
            end
            FULL: begin
                if (adv_fire) begin
                    // sum is below 32, so its low nibble is either s or s-16.
                    ptr_nxt = sum[PTR_WIDTH-1:0];
                    if (drop) begin
                        window_nxt[IN_WIDTH-1:0] = window[WINDOW_WIDTH-1:IN_WIDTH];
                        if (accept) begin
                            window_nxt[WINDOW_WIDTH-1:IN_WIDTH] = i_data;
                            state_nxt                           = FULL;
                        end else begin
                            state_nxt = HALF;
                        end
                    end
                end
            end
            default: begin
                state_nxt = EMPTY;
            end
        endcase

        if (flush_req) begin
            state_nxt  = EMPTY;
            window_nxt = '0;
            ptr_nxt    = '0;
        end
    end

    // Ready is held low during reset regardless of window occupancy.
    always_comb begin
        i_ready = ~rst & ready;
    end

    // Registered window drives the selector directly.
    always_comb begin
        o_valid    = (state == FULL);
        o_en       = (state == FULL);
        o_data_bus = window;
        o_ptr      = ptr;
    end

    bit_sel_cmd_encode u_cmd_encode (
        .ptr (ptr),
        .cmd (o_cmd)
    );

endmodule

// File: tb/tb_bit_window_feeder_32.sv
// Bench for bit_window_feeder_32: directed walk through the main scenarios,
// then randomized traffic against a word-queue reference model.
module tb_bit_window_feeder_32;

    logic        clk;
    logic        rst;
    logic        i_valid;
    logic        i_ready;
    logic [15:0] i_data;
    logic        i_adv_valid;
    logic [4:0]  i_adv_len;
    logic        flush_drv;
    logic        o_valid;
    logic        o_en;
    logic [31:0] o_data_bus;
    logic [4:0]  o_cmd;
    logic [3:0]  o_ptr;

    int n_checks;
    int n_fail;

    // Reference model: words currently held (oldest first) and bit pointer.
    logic [15:0] mq[$];
    int          mp;

    bit_window_feeder_32 dut (
        .clk         (clk),
        .rst         (rst),
        .i_valid     (i_valid),
        .i_ready     (i_ready),
        .i_data      (i_data),
        .i_adv_valid (i_adv_valid),
        .i_adv_len   (i_adv_len),
`ifdef BIT_WINDOW_FLUSH_EN
        .i_flush     (flush_drv),
`endif
        .o_valid     (o_valid),
        .o_en        (o_en),
        .o_data_bus  (o_data_bus),
        .o_cmd       (o_cmd),
        .o_ptr       (o_ptr)
    );

    // Clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    // Registered outputs against the model.
    task automatic check_outputs();
        int exp_cmd;
        exp_cmd = (mp == 0) ? 0 : 16 + mp - 1;
        check_eq("o_valid", o_valid, mq.size() == 2);
        check_eq("o_en", o_en, mq.size() == 2);
        check_eq("o_ptr", o_ptr, mp);
        check_eq("o_cmd", o_cmd, exp_cmd);
        if (mq.size() == 2) begin
            check_eq("o_data_bus", o_data_bus, {mq[1], mq[0]});
        end else if (mq.size() == 1) begin
            check_eq("o_data_bus_lo", o_data_bus[15:0], mq[0]);
        end
    endtask

    // One clock cycle: drive, check i_ready, clock, update model, check outputs.
    task automatic step(input logic r, input logic v, input logic [15:0] d,
                        input logic av, input logic [4:0] al, input logic fl);
        int   ls;
        int   s;
        logic full;
        logic fire;
        logic drop;
        logic rdy_exp;
        logic acc;
        rst         = r;
        i_valid     = v;
        i_data      = d;
        i_adv_valid = av;
        i_adv_len   = al;
        flush_drv   = fl;
        #1;
        full    = (mq.size() == 2);
        ls      = (al > 5'd16) ? 16 : int'(al);
        s       = mp + ls;
        fire    = av && full;
        drop    = fire && (s >= 16);
        rdy_exp = !r && !fl && (!full || drop);
        check_eq("i_ready", i_ready, rdy_exp);
        acc = v && rdy_exp;
        @(posedge clk);
        #1;
        if (r || fl) begin
            mq.delete();
            mp = 0;
        end else begin
            if (fire) begin
                if (s >= 16) begin
                    void'(mq.pop_front());
                    mp = s - 16;
                end else begin
                    mp = s;
                end
            end
            if (acc) mq.push_back(d);
        end
        check_outputs();
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        mp          = 0;
        rst         = 1'b1;
        i_valid     = 1'b0;
        i_data      = '0;
        i_adv_valid = 1'b0;
        i_adv_len   = '0;
        flush_drv   = 1'b0;
        @(posedge clk);
        #1;

        // Reset held two cycles with a word offered.
        step(1, 1, 16'hFFFF, 0, 0, 0);
        step(1, 1, 16'hFFFF, 0, 0, 0);
        check_eq("reset_bus", o_data_bus, 32'h0);
        check_eq("reset_cmd", o_cmd, 5'b00000);

        // Fill the window.
        step(0, 1, 16'h0810, 0, 0, 0);
        step(0, 1, 16'hA442, 0, 0, 0);
        check_eq("fill_bus", o_data_bus, 32'hA4420810);
        check_eq("fill_valid", o_valid, 1'b1);
        check_eq("fill_ready", i_ready, 1'b0);

        // Pointer advances inside the window.
        step(0, 0, 16'h0, 1, 5'd1, 0);
        check_eq("adv1_cmd", o_cmd, 5'b10000);
        step(0, 0, 16'h0, 1, 5'd4, 0);
        check_eq("adv4_cmd", o_cmd, 5'b10100);
        step(0, 0, 16'h0, 1, 5'd0, 0);
        check_eq("adv0_ptr", o_ptr, 4'd5);

        // Drop with same-cycle refill.
        step(0, 1, 16'h1234, 1, 5'd12, 0);
        check_eq("refill_bus", o_data_bus, 32'h1234A442);
        check_eq("refill_cmd", o_cmd, 5'b10000);
        check_eq("refill_valid", o_valid, 1'b1);

        // Drop to HALF, refill, full-word and saturated advances.
        step(0, 0, 16'h0, 1, 5'd15, 0);
        check_eq("half_valid", o_valid, 1'b0);
        check_eq("half_ptr", o_ptr, 4'd0);
        step(0, 1, 16'h5678, 0, 0, 0);
        check_eq("push_bus", o_data_bus, 32'h56781234);
        step(0, 0, 16'h0, 1, 5'd16, 0);
        step(0, 1, 16'h9ABC, 0, 0, 0);
        step(0, 0, 16'h0, 1, 5'd20, 0);
        check_eq("sat_valid", o_valid, 1'b0);
        check_eq("sat_ptr", o_ptr, 4'd0);
        check_eq("sat_bus_lo", o_data_bus[15:0], 16'h9ABC);

        // Reset while FULL at p=7 with an advance pending.
        step(0, 1, 16'h1111, 0, 0, 0);
        step(0, 0, 16'h0, 1, 5'd7, 0);
        check_eq("p7_ptr", o_ptr, 4'd7);
        step(1, 1, 16'h2222, 1, 5'd3, 0);
        check_eq("rst_valid", o_valid, 1'b0);
        check_eq("rst_ptr", o_ptr, 4'd0);
        check_eq("rst_cmd", o_cmd, 5'b00000);

`ifdef BIT_WINDOW_FLUSH_EN
        // Flush while FULL at p=7.
        step(0, 1, 16'h3333, 0, 0, 0);
        step(0, 1, 16'h4444, 0, 0, 0);
        step(0, 0, 16'h0, 1, 5'd7, 0);
        step(0, 1, 16'h5555, 1, 5'd12, 1);
        check_eq("flush_valid", o_valid, 1'b0);
        check_eq("flush_ptr", o_ptr, 4'd0);
`endif

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic r;
            logic v;
            logic av;
            logic fl;
            r  = ($urandom_range(0, 99) == 0);
            v  = ($urandom_range(0, 9) < 7);
            av = ($urandom_range(0, 9) < 6);
            fl = 1'b0;
`ifdef BIT_WINDOW_FLUSH_EN
            fl = ($urandom_range(0, 63) == 0);
`endif
            step(r, v, 16'($urandom), av, 5'($urandom_range(0, 20)), fl);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
